mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares one single-ported, fixed-latency unified memory between the instruction fetch stage and the MEM stage.
- Sequences each access through a small FSM and a latency counter, and returns data with a one-cycle ack.
- Drives the stall signals that freeze PC / IF_ID (fetch side) and the whole pipeline (data side) while a requester waits.
- Sits between the fetch/memory stages and the memory macro; the pipeline registers consume its stall outputs.

Parameters:
- ADDR_W, 64, address width of all address ports.
- DATA_W, 64, data-side and memory data width.
- INSTR_W, 32, instruction width (low INSTR_W bits of mem_rdata).
- MEM_LAT, 2, cycles from mem_en cycle to mem_rdata valid; must be >=1, elaboration error otherwise.
- STARVE_MAX, 4, consecutive data grants while if_req waits before fetch is forced.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address; stable while if_req.
- if_rdata  out  INSTR_W  fetched instruction.
- if_ack  out  1  one-cycle fetch completion.
- d_req  in  1  data request; held until d_ack.
- d_we  in  1  1=write, 0=read.
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_rdata  out  DATA_W  load data.
- d_ack  out  1  one-cycle data completion.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data.
- stall_if  out  1  = if_req & ~if_ack.
- stall_mem  out  1  = d_req & ~d_ack.

Behaviour:
- Reset (reset=0, any time, including mid-transaction):
  - FSM to IDLE; counter, starve count and capture registers cleared.
  - All outputs 0 while reset is asserted; no ack is issued for the aborted access.
- FSM states IDLE, BUSY_I, BUSY_D. Requests are sampled only in IDLE.
- IDLE grant rule:
  - Only d_req: go to BUSY_D.
  - Only if_req: go to BUSY_I.
  - Both: BUSY_D, unless starve_cnt == STARVE_MAX, then BUSY_I.
  - Neither: stay in IDLE.
- Entry into BUSY_x:
  - Latches addr, we and wdata of the granted requester (fetch: we=0, wdata=0).
  - Loads cnt=MEM_LAT.
- BUSY cycles:
  - First BUSY cycle: mem_en=1; mem_we/mem_addr/mem_wdata from the latches.
  - Other cycles: mem_en=0, mem_we=0; mem_addr/mem_wdata hold.
  - cnt decrements each BUSY cycle.
- Ack cycle (cnt==0):
  - Matching ack=1.
  - Read data is mem_rdata passed through (if_rdata = mem_rdata[INSTR_W-1:0]) and captured at the clock edge.
  - Outside ack, rdata outputs show the last captured value (0 after reset).
  - FSM returns to IDLE.
- Latency:
  - Request seen in IDLE cycle t0 → mem_en in t1 → ack in t1+MEM_LAT.
  - BUSY lasts MEM_LAT+1 cycles; minimum one IDLE cycle between transactions.
- Writes use identical timing; d_rdata is not updated on writes.
- Starve counter:
  - +1 (saturating at STARVE_MAX) on each BUSY_D grant while if_req=1.
  - Cleared on a BUSY_I grant or when if_req=0 in IDLE.
- Request withdrawn mid-transaction: the access still completes and ack still pulses; no cancel.
- Requests arriving while BUSY wait; their stall output stays high.
- The ack/stall outputs are combinational from state/cnt plus the req inputs; there is no combinational path from addr/data inputs to mem_* outputs.

Optional Feature:
- ARB_PERF_CNT_EN defined:
  - Adds outputs perf_if_stall[31:0] and perf_d_stall[31:0].
  - Each increments every cycle its stall output is 1, saturating at 2^32-1, cleared by reset.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - State typedef {IDLE, BUSY_I, BUSY_D}.
  - Grant encoding constants GNT_NONE/GNT_I/GNT_D.
  - Default width constants.
- One sub-module arb_lat_counter: load / decrement / zero flag, MEM_LAT-sized; instantiated once.
- Grant logic and FSM stay in the top module.

Test Plan (MEM_LAT=2, STARVE_MAX=4):
- Fetch only, if_req at t0 with if_addr=0x40 → mem_en t1 (addr 0x40), if_ack t3, if_rdata=mem_rdata[31:0], stall_if high t0–t2.
- Simultaneous if_req and d_req (read 0x100) at t0 → data served first (d_ack t3); fetch mem_en t5, if_ack t7.
- Store d_we=1, addr 0x8, wdata 0xDEAD → mem_en=mem_we=1 for t1 only, d_ack t3, d_rdata unchanged.
- d_req held continuously with if_req high → after 4 data grants the next grant goes to fetch; starve_cnt then clears.
- reset driven low mid-BUSY_D at t2 → outputs 0 immediately, no d_ack; after release a new request completes normally in 3 cycles.
- With ARB_PERF_CNT_EN, scenario 2 → perf_if_stall=7, perf_d_stall=3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and default widths for the memory port arbiter
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  typedef logic [1:0] gnt_t;

  localparam gnt_t GNT_NONE = 2'd0;
  localparam gnt_t GNT_I    = 2'd1;
  localparam gnt_t GNT_D    = 2'd2;

  localparam int DEF_ADDR_W     = 64;
  localparam int DEF_DATA_W     = 64;
  localparam int DEF_INSTR_W    = 32;
  localparam int DEF_MEM_LAT    = 2;
  localparam int DEF_STARVE_MAX = 4;

endpackage

// File: rtl/arb_lat_counter.sv
// rtl/arb_lat_counter.sv - loadable down-counter timing one memory access
module arb_lat_counter
  import mem_arb_pkg::*;
#(
  parameter int MEM_LAT = DEF_MEM_LAT,
  parameter int CNT_W   = $clog2(MEM_LAT + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             load,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(MEM_LAT);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one fixed-latency memory port
// Optional ARB_PERF_CNT_EN adds saturating stall-cycle counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int INSTR_W    = DEF_INSTR_W,
  parameter int MEM_LAT    = DEF_MEM_LAT,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               if_req,
  input  logic [ADDR_W-1:0]  if_addr,
  output logic [INSTR_W-1:0] if_rdata,
  output logic               if_ack,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [ADDR_W-1:0]  d_addr,
  input  logic [DATA_W-1:0]  d_wdata,
  output logic [DATA_W-1:0]  d_rdata,
  output logic               d_ack,
  output logic               mem_en,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [DATA_W-1:0]  mem_wdata,
  input  logic [DATA_W-1:0]  mem_rdata,
  output logic               stall_if,
  output logic               stall_mem
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]        perf_if_stall,
  output logic [31:0]        perf_d_stall
`endif
);

  localparam int CNT_W = $clog2(MEM_LAT + 1);
  localparam int SW    = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

  if (MEM_LAT < 1) begin : g_bad_lat
    $error("mem_port_arbiter: MEM_LAT must be >= 1");
  end

  arb_state_t         state_q, state_d;
  gnt_t               gnt;
  logic [CNT_W-1:0]   cnt;
  logic               cnt_zero;
  logic               busy;
  logic               first_cyc;
  logic               starved;
  logic [SW-1:0]      starve_q;
  logic [ADDR_W-1:0]  addr_q;
  logic               we_q;
  logic [DATA_W-1:0]  wdata_q;
  logic [INSTR_W-1:0] if_rdata_q;
  logic [DATA_W-1:0]  d_rdata_q;

  arb_lat_counter #(
    .MEM_LAT (MEM_LAT),
    .CNT_W   (CNT_W)
  ) u_lat_cnt (
    .clock (clock),
    .reset (reset),
    .load  (gnt != GNT_NONE),
    .dec   (busy),
    .cnt   (cnt),
    .zero  (cnt_zero)
  );

  assign busy      = (state_q != IDLE);
  assign first_cyc = busy && (cnt == CNT_W'(MEM_LAT));
  assign starved   = (starve_q == SW'(STARVE_MAX));

  // Data wins ties so loads/stores drain first, unless fetch has waited too long.
  always_comb begin
    gnt = GNT_NONE;
    if (state_q == IDLE) begin
      if (d_req && if_req) begin
        gnt = starved ? GNT_I : GNT_D;
      end else if (d_req) begin
        gnt = GNT_D;
      end else if (if_req) begin
        gnt = GNT_I;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (gnt == GNT_D) begin
          state_d = BUSY_D;
        end else if (gnt == GNT_I) begin
          state_d = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (cnt_zero) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      starve_q   <= '0;
    end else begin
      state_q <= state_d;
      if (gnt == GNT_D) begin
        addr_q  <= d_addr;
        we_q    <= d_we;
        wdata_q <= d_wdata;
      end else if (gnt == GNT_I) begin
        addr_q  <= if_addr;
        we_q    <= 1'b0;
        wdata_q <= '0;
      end
      if (if_ack) begin
        if_rdata_q <= mem_rdata[INSTR_W-1:0];
      end
      if (d_ack && !we_q) begin
        d_rdata_q <= mem_rdata;
      end
      // Counts data grants that overtook a waiting fetch.
      if (gnt == GNT_D && if_req) begin
        if (!starved) begin
          starve_q <= starve_q + SW'(1);
        end
      end else if (gnt == GNT_I || (state_q == IDLE && !if_req)) begin
        starve_q <= '0;
      end
    end
  end

  assign if_ack    = (state_q == BUSY_I) && cnt_zero;
  assign d_ack     = (state_q == BUSY_D) && cnt_zero;
  assign stall_if  = reset && if_req && !if_ack;
  assign stall_mem = reset && d_req && !d_ack;

  assign mem_en    = first_cyc;
  assign mem_we    = first_cyc && we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_rdata  = if_ack ? mem_rdata[INSTR_W-1:0] : if_rdata_q;
  assign d_rdata   = (d_ack && !we_q) ? mem_rdata : d_rdata_q;

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_if_stall <= '0;
      perf_d_stall  <= '0;
    end else begin
      if (stall_if && (perf_if_stall != '1)) begin
        perf_if_stall <= perf_if_stall + 32'd1;
      end
      if (stall_mem && (perf_d_stall != '1)) begin
        perf_d_stall <= perf_d_stall + 32'd1;
      end
    end
  end
`endif

endmodule
